decode_stage: RTL and testbench

- Second pipeline stage, directly downstream of instruction fetch.
- Registers the fetched word and its PC, splits it into fields, and sign-extends immediates.
- Detects load-use hazards with a small in-flight load scoreboard and stalls fetch on a hit.
- Supplies the static branch prediction (pc_pred, pred_taken) that fetch consumes.

---
 rtl/decode_pkg.sv | 64 ++++++
 rtl/decode_stage_load_scoreboard.sv | 59 +++++
 rtl/decode_stage.sv | 117 +++++++++++
 tb/tb_decode_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction classes, field positions, the decoded
// bundle type and the field-extraction helper used by the decode stage.
package decode_pkg;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_LD  = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_CMP = 2'b11;

  localparam int COND_MSB   = 31;
  localparam int COND_LSB   = 30;
  localparam int CLS_MSB    = 29;
  localparam int CLS_LSB    = 28;
  localparam int OP_MSB     = 27;
  localparam int OP_LSB     = 24;
  localparam int RD_MSB     = 23;
  localparam int RD_LSB     = 20;
  localparam int RS1_MSB    = 19;
  localparam int RS1_LSB    = 16;
  localparam int RS2_MSB    = 15;
  localparam int RS2_LSB    = 12;
  localparam int IMM16_MSB  = 15;
  localparam int IMM24_MSB  = 23;
  localparam int BR_DIR_BIT = 23;
  localparam int REG_W      = 4;

  typedef struct packed {
    logic             valid;
    logic [1:0]       cond;
    logic [1:0]       cls;
    logic [3:0]       alu_op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [31:0]      imm;
    logic             we;
    logic [31:0]      pc;
  } decoded_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] sext24(input logic [23:0] v);
    return {{8{v[23]}}, v};
  endfunction

  // Branches carry a 24-bit displacement that overlaps the register fields.
  function automatic decoded_t decode_word(input logic [31:0] instr, input logic [31:0] pc);
    decoded_t b;
    b.valid  = 1'b1;
    b.cond   = instr[COND_MSB:COND_LSB];
    b.cls    = instr[CLS_MSB:CLS_LSB];
    b.alu_op = instr[OP_MSB:OP_LSB];
    b.rd     = instr[RD_MSB:RD_LSB];
    b.rs1    = instr[RS1_MSB:RS1_LSB];
    b.rs2    = instr[RS2_MSB:RS2_LSB];
    b.imm    = (b.cls == CLS_BR) ? sext24(instr[IMM24_MSB:0]) : sext16(instr[IMM16_MSB:0]);
    b.we     = (b.cls == CLS_ALU) || (b.cls == CLS_LD);
    b.pc     = pc;
    return b;
  endfunction

endpackage

// File: rtl/decode_stage_load_scoreboard.sv
// In-flight load tracker: a shift chain of {valid, rd} entries, one per cycle
// of load latency, with a source-register hit compare across every entry.
module load_scoreboard
  import decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [RW-1:0] push_rd,
  input  logic          advance,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic          use_rs2,
  output logic          hit
);

  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [DEPTH-1:0][RW-1:0] rd_q, rd_d;

  // Shift the chain on accepted cycles; the oldest entry drops off the end.
  always_comb begin
    vld_d = vld_q;
    rd_d  = rd_q;
    if (advance) begin
      vld_d[0] = push;
      rd_d[0]  = push_rd;
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        rd_d[i]  = rd_q[i-1];
      end
    end else begin
      vld_d = vld_q;
      rd_d  = rd_q;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      rd_q  <= '0;
    end else begin
      vld_q <= vld_d;
      rd_q  <= rd_d;
    end
  end

  // Any valid entry matching a consumed source register is a hit.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit = hit | (vld_q[i] & ((rd_q[i] == rs1) | (use_rs2 & (rd_q[i] == rs2))));
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: registers the fetched word, splits fields, stalls on
// load-use hazards and produces the static backward-taken branch prediction.
module decode_stage
  import decode_pkg::*;
#(
  parameter int LOAD_LAT = 2,
  parameter int NREG     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic        instr_valid,
  input  logic        br_taken,
  input  logic        ex_ready,
  output logic        stall_fetch,
  output logic        pred_taken,
  output logic [31:0] pc_pred,
  output logic        d_valid,
  output logic [1:0]  d_cond,
  output logic [1:0]  d_class,
  output logic [3:0]  d_alu_op,
  output logic [3:0]  d_rd,
  output logic [3:0]  d_rs1,
  output logic [3:0]  d_rs2,
  output logic [31:0] d_imm,
  output logic        d_we,
  output logic [31:0] d_pc
);

  localparam int RW = $clog2(NREG);

  decoded_t    dec;
  decoded_t    bundle_q, bundle_d;
  logic        pred_taken_q, pred_taken_d;
  logic [31:0] pc_pred_q, pc_pred_d;
  logic        sb_hit, hazard, issue, push_load, use_rs2, predict_bwd;
  logic [31:0] br_target;

  assign dec         = decode_word(instr_in, pc_in);
  assign use_rs2     = (dec.cls == CLS_ALU) || (dec.cls == CLS_CMP);
  assign hazard      = instr_valid & sb_hit;
  assign issue       = instr_valid & ~hazard & ex_ready & ~br_taken;
  assign push_load   = issue & (dec.cls == CLS_LD);
  assign br_target   = pc_in + dec.imm;
  assign predict_bwd = issue & (dec.cls == CLS_BR) & instr_in[BR_DIR_BIT];

  // Stall is suppressed while in reset so fetch sees a quiet interface.
  assign stall_fetch = ~rst & (hazard | ~ex_ready) & ~br_taken;

  load_scoreboard #(
    .DEPTH (LOAD_LAT),
    .RW    (RW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .push    (push_load),
    .push_rd (dec.rd[RW-1:0]),
    .advance (ex_ready),
    .rs1     (dec.rs1[RW-1:0]),
    .rs2     (dec.rs2[RW-1:0]),
    .use_rs2 (use_rs2),
    .hit     (sb_hit)
  );

  // Output update priority: flush, back-pressure hold, hazard bubble, load.
  always_comb begin
    bundle_d     = bundle_q;
    pred_taken_d = pred_taken_q;
    pc_pred_d    = pc_pred_q;
    if (br_taken) begin
      bundle_d.valid = 1'b0;
      pred_taken_d   = 1'b0;
      pc_pred_d      = 32'h0000_0000;
    end else if (!ex_ready) begin
      bundle_d     = bundle_q;
      pred_taken_d = pred_taken_q;
      pc_pred_d    = pc_pred_q;
    end else if (hazard) begin
      bundle_d.valid = 1'b0;
      pred_taken_d   = 1'b0;
      pc_pred_d      = 32'h0000_0000;
    end else begin
      bundle_d       = dec;
      bundle_d.valid = instr_valid;
      pred_taken_d   = predict_bwd;
      pc_pred_d      = predict_bwd ? br_target : 32'h0000_0000;
    end
  end

  // Decoded bundle and prediction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bundle_q     <= '0;
      pred_taken_q <= 1'b0;
      pc_pred_q    <= 32'h0000_0000;
    end else begin
      bundle_q     <= bundle_d;
      pred_taken_q <= pred_taken_d;
      pc_pred_q    <= pc_pred_d;
    end
  end

  assign pred_taken = pred_taken_q;
  assign pc_pred    = pc_pred_q;
  assign d_valid    = bundle_q.valid;
  assign d_cond     = bundle_q.cond;
  assign d_class    = bundle_q.cls;
  assign d_alu_op   = bundle_q.alu_op;
  assign d_rd       = bundle_q.rd;
  assign d_rs1      = bundle_q.rs1;
  assign d_rs2      = bundle_q.rs2;
  assign d_imm      = bundle_q.imm;
  assign d_we       = bundle_q.we;
  assign d_pc       = bundle_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a vector table for single-cycle decode
// behaviour plus sequences for load-use, flush/back-pressure and reset.
module tb_decode_stage;

  logic        clk, rst;
  logic [31:0] instr_in, pc_in;
  logic        instr_valid, br_taken, ex_ready;

  logic        stall_a, pt_a, dv_a, we_a;
  logic [31:0] pp_a, imm_a, pc_a;
  logic [1:0]  cond_a, cls_a;
  logic [3:0]  op_a, rd_a, rs1_a, rs2_a;

  logic        stall_b, pt_b, dv_b, we_b;
  logic [31:0] pp_b, imm_b, pc_b;
  logic [1:0]  cond_b, cls_b;
  logic [3:0]  op_b, rd_b, rs1_b, rs2_b;

  decode_stage #(.LOAD_LAT(2), .NREG(16)) u_dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .instr_valid(instr_valid),
    .br_taken(br_taken), .ex_ready(ex_ready), .stall_fetch(stall_a), .pred_taken(pt_a),
    .pc_pred(pp_a), .d_valid(dv_a), .d_cond(cond_a), .d_class(cls_a), .d_alu_op(op_a),
    .d_rd(rd_a), .d_rs1(rs1_a), .d_rs2(rs2_a), .d_imm(imm_a), .d_we(we_a), .d_pc(pc_a)
  );

  decode_stage #(.LOAD_LAT(1), .NREG(16)) u_dut_lat1 (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .instr_valid(instr_valid),
    .br_taken(br_taken), .ex_ready(ex_ready), .stall_fetch(stall_b), .pred_taken(pt_b),
    .pc_pred(pp_b), .d_valid(dv_b), .d_cond(cond_b), .d_class(cls_b), .d_alu_op(op_b),
    .d_rd(rd_b), .d_rs1(rs1_b), .d_rs2(rs2_b), .d_imm(imm_b), .d_we(we_b), .d_pc(pc_b)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        rdy;
    logic        br;
    logic        stall;
    logic        chkf;
    logic        e_valid;
    logic [1:0]  e_cond;
    logic [1:0]  e_cls;
    logic [3:0]  e_op;
    logic [3:0]  e_rd;
    logic [3:0]  e_rs1;
    logic [3:0]  e_rs2;
    logic [31:0] e_imm;
    logic        e_we;
    logic [31:0] e_pc;
    logic        e_pt;
    logic [31:0] e_pp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic v, input logic rdy, input logic br);
    instr_in    = instr;
    pc_in       = pc;
    instr_valid = v;
    ex_ready    = rdy;
    br_taken    = br;
  endtask

  task automatic idle(input int n);
    drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    repeat (n) tick();
  endtask

  // Load to r2 followed by a dependent ALU op; counts bubbles on one instance.
  task automatic load_use(input logic lat1, input int exp_bubbles, input logic [31:0] pc0);
    int   bubbles;
    logic st;
    drive(32'h10200004, pc0, 1'b1, 1'b1, 1'b0);
    #2;
    chk("lu_load_stall", 32'(lat1 ? stall_b : stall_a), 32'h0);
    tick();
    chk("lu_load_dvalid", 32'(lat1 ? dv_b : dv_a), 32'h1);
    chk("lu_load_class", 32'(lat1 ? cls_b : cls_a), 32'h1);
    drive(32'h06320000, pc0 + 32'h4, 1'b1, 1'b1, 1'b0);
    bubbles = 0;
    for (int c = 0; c < 8; c++) begin
      #2;
      st = lat1 ? stall_b : stall_a;
      tick();
      if (!st) break;
      bubbles++;
      chk("lu_bubble_dvalid", 32'(lat1 ? dv_b : dv_a), 32'h0);
    end
    chk("lu_bubbles", 32'(bubbles), 32'(exp_bubbles));
    chk("lu_alu_dvalid", 32'(lat1 ? dv_b : dv_a), 32'h1);
    chk("lu_alu_rd", 32'(lat1 ? rd_b : rd_a), 32'h3);
    chk("lu_alu_pc", lat1 ? pc_b : pc_a, pc0 + 32'h4);
  endtask

  initial begin
    int   n;
    logic st;

    vecs[0]  = '{32'h06100003, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 4'h6, 4'h1, 4'h0, 4'h0, 32'h3, 1'b1, 32'h0, 1'b0, 32'h0};
    vecs[1]  = '{32'h20FFFFFC, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 4'h0, 4'hF, 4'hF, 4'hF, 32'hFFFFFFFC, 1'b0, 32'h8, 1'b1, 32'h4};
    vecs[2]  = '{32'h20000004, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 4'h0, 4'h0, 4'h0, 4'h0, 32'h4, 1'b0, 32'h8, 1'b0, 32'h0};
    vecs[3]  = '{32'h20FFFFFF, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 4'h0, 4'hF, 4'hF, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF};
    vecs[4]  = '{32'hF3A5B800, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 2'd3, 4'h3, 4'hA, 4'h5, 4'hB, 32'hFFFFB800, 1'b0, 32'h100, 1'b0, 32'h0};
    vecs[5]  = '{32'h5C7E8ABC, 32'h44, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 4'hC, 4'h7, 4'hE, 4'h8, 32'hFFFF8ABC, 1'b1, 32'h44, 1'b0, 32'h0};
    vecs[6]  = '{32'h01234567, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'h1, 4'h2, 4'h3, 4'h4, 32'h4567, 1'b1, 32'h10, 1'b0, 32'h0};
    vecs[7]  = '{32'h06000000, 32'h50, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 4'h1, 4'h2, 4'h3, 4'h4, 32'h4567, 1'b1, 32'h10, 1'b0, 32'h0};
    vecs[8]  = '{32'h0A9870F0, 32'h20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[9]  = '{32'h0A9870F0, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 4'hA, 4'h9, 4'h8, 4'h7, 32'h70F0, 1'b1, 32'h20, 1'b0, 32'h0};
    vecs[10] = '{32'h06777000, 32'h60, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[11] = '{32'h10500000, 32'h30, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 4'h0, 4'h5, 4'h0, 4'h0, 32'h0, 1'b1, 32'h30, 1'b0, 32'h0};
    vecs[12] = '{32'h15025000, 32'h34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 4'h5, 4'h0, 4'h2, 4'h5, 32'h5000, 1'b1, 32'h34, 1'b0, 32'h0};
    vecs[13] = '{32'h30015000, 32'h38, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[14] = '{32'h20000010, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[15] = '{32'h20000010, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 4'h0, 4'h0, 4'h0, 4'h0, 32'h10, 1'b0, 32'h40, 1'b0, 32'h0};

    // Reset held with random inputs: every output stays zero.
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk);
      #2;
      chk("rst_dvalid", 32'(dv_a), 32'h0);
      chk("rst_stall", 32'(stall_a), 32'h0);
      chk("rst_pred", {31'h0, pt_a} | pp_a, 32'h0);
      chk("rst_fields", {16'h0, cond_a, cls_a, op_a, rd_a, rs1_a, rs2_a} | imm_a | pc_a | 32'(we_a), 32'h0);
    end
    drive(32'h06100003, 32'hC, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_release_dvalid", 32'(dv_a), 32'h0);
    chk("rst_release_stall", 32'(stall_a), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_first_dvalid", 32'(dv_a), 32'h1);
    chk("rst_first_pc", pc_a, 32'hC);
    chk("rst_first_rd", 32'(rd_a), 32'h1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].valid, vecs[i].rdy, vecs[i].br);
      #2;
      chk($sformatf("v%0d_stall", i), 32'(stall_a), 32'(vecs[i].stall));
      tick();
      chk($sformatf("v%0d_valid", i), 32'(dv_a), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_pred_taken", i), 32'(pt_a), 32'(vecs[i].e_pt));
      if (vecs[i].chkf) begin
        chk($sformatf("v%0d_pc_pred", i), pp_a, vecs[i].e_pp);
        chk($sformatf("v%0d_cond", i), 32'(cond_a), 32'(vecs[i].e_cond));
        chk($sformatf("v%0d_class", i), 32'(cls_a), 32'(vecs[i].e_cls));
        chk($sformatf("v%0d_alu_op", i), 32'(op_a), 32'(vecs[i].e_op));
        chk($sformatf("v%0d_rd", i), 32'(rd_a), 32'(vecs[i].e_rd));
        chk($sformatf("v%0d_rs1", i), 32'(rs1_a), 32'(vecs[i].e_rs1));
        chk($sformatf("v%0d_rs2", i), 32'(rs2_a), 32'(vecs[i].e_rs2));
        chk($sformatf("v%0d_imm", i), imm_a, vecs[i].e_imm);
        chk($sformatf("v%0d_we", i), 32'(we_a), 32'(vecs[i].e_we));
        chk($sformatf("v%0d_pc", i), pc_a, vecs[i].e_pc);
      end
    end

    idle(3);
    load_use(1'b0, 2, 32'h200);
    idle(3);
    load_use(1'b1, 1, 32'h300);
    idle(3);

    // Back-pressure hold, then a flush that overrides it; load to r4 stays pending.
    drive(32'h10400000, 32'h70, 1'b1, 1'b1, 1'b0);
    #2;
    chk("fl_load_stall", 32'(stall_a), 32'h0);
    tick();
    chk("fl_load_dvalid", 32'(dv_a), 32'h1);
    drive(32'h06040000, 32'h74, 1'b1, 1'b0, 1'b0);
    #2;
    chk("bp_stall", 32'(stall_a), 32'h1);
    tick();
    chk("bp_hold_dvalid", 32'(dv_a), 32'h1);
    chk("bp_hold_pc", pc_a, 32'h70);
    drive(32'h06040000, 32'h74, 1'b1, 1'b0, 1'b1);
    #2;
    chk("fl_stall", 32'(stall_a), 32'h0);
    tick();
    chk("fl_dvalid", 32'(dv_a), 32'h0);
    chk("fl_pred_taken", 32'(pt_a), 32'h0);
    drive(32'h06040000, 32'h74, 1'b1, 1'b1, 1'b0);
    #2;
    chk("fl_pending_stall", 32'(stall_a), 32'h1);
    tick();
    chk("fl_pending_dvalid", 32'(dv_a), 32'h0);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      #2;
      st = stall_a;
      tick();
      if (!st) break;
      n++;
    end
    chk("fl_extra_stalls", 32'(n), 32'h1);
    chk("fl_issue_dvalid", 32'(dv_a), 32'h1);
    chk("fl_issue_pc", pc_a, 32'h74);
    idle(3);

    // Reset asserted during a load-use stall.
    drive(32'h10200004, 32'h80, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h06320000, 32'h84, 1'b1, 1'b1, 1'b0);
    #2;
    chk("rs_stall_before", 32'(stall_a), 32'h1);
    rst = 1'b1;
    #1;
    chk("rs_stall_async", 32'(stall_a), 32'h0);
    chk("rs_dvalid_async", 32'(dv_a), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("rs_stall_after", 32'(stall_a), 32'h0);
    tick();
    chk("rs_issue_dvalid", 32'(dv_a), 32'h1);
    chk("rs_issue_rd", 32'(rd_a), 32'h3);
    chk("rs_issue_pc", pc_a, 32'h84);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
